// File: rtl/bcd_a_binario_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
// Contents: FSM state encoding, nibble and BCD correction constants, and the
// counter width helper.
package bcd_a_binario_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic [NIBBLE_W-1:0] BCD_MAX     = 4'd9;
  localparam logic [NIBBLE_W-1:0] BCD_CORR_TH = 4'd8;
  localparam logic [NIBBLE_W-1:0] BCD_CORR    = 4'd3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StShift = SHIFT,
    StDone  = DONE
  } state_e;

  // The counter has to hold the value bin_w, so it needs $clog2(bin_w+1) bits.
  function automatic int unsigned cnt_width(input int unsigned bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bcd_a_binario_seq_if.sv
// Start/busy/done handshake bundle for the BCD-to-binary converter.
// master: drives start and bcd_in, observes busy, done, bin_out and err.
// slave : the converter side.
interface bcd_a_binario_seq_if #(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) ();

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  done,
    input  bin_out,
    input  err
  );

  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output done,
    output bin_out,
    output err
  );

endinterface

// File: rtl/bcd_nibble_corr.sv
// Reverse double-dabble correction for one BCD nibble.
// Ports: din  - nibble after the right shift
//        dout - din-3 when din >= 8, otherwise din (4-bit, no carry out)
module bcd_nibble_corr
  import bcd_a_binario_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] din,
  output logic [NIBBLE_W-1:0] dout
);

  assign dout = (din >= BCD_CORR_TH) ? (din - BCD_CORR) : din;

endmodule

// File: rtl/bcd_a_binario_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble: one right
// shift per clock, with a -3 correction on every BCD nibble >= 8 afterwards.
// Ports: clk   - rising-edge clock
//        rst_n - asynchronous active-low reset
//        bus   - slave side of the start/busy/done handshake
//                (start, bcd_in in; busy, done, bin_out, err out)
module bcd_a_binario_seq
  import bcd_a_binario_seq_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  bcd_a_binario_seq_if.slave  bus
);

  localparam int unsigned BCD_W = NIBBLE_W * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = cnt_width(BIN_W);

  state_e            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [SR_W-1:0]   sr_shift;
  logic [BCD_W-1:0]  bcd_corr;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              err_q, err_d;
  logic              corr_en;
  logic              in_invalid;

  assign sr_shift = sr_q >> 1;

  // The last shift gets no correction; at that point the BCD part must be zero.
  assign corr_en = (cnt_q < CNT_W'(BIN_W - 1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_nibble_corr u_corr (
      .din  (sr_shift[BIN_W + g*NIBBLE_W +: NIBBLE_W]),
      .dout (bcd_corr[g*NIBBLE_W +: NIBBLE_W])
    );
  end

  always_comb begin
    in_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[i*NIBBLE_W +: NIBBLE_W] > BCD_MAX) begin
        in_invalid = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sr_d  = {bus.bcd_in, {BIN_W{1'b0}}};
          cnt_d = '0;
          if (in_invalid) begin
            state_d = StDone;
            bin_d   = '0;
            err_d   = 1'b1;
          end else begin
            state_d = StShift;
          end
        end
      end
      StShift: begin
        sr_d  = corr_en ? {bcd_corr, sr_shift[BIN_W-1:0]} : sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (!corr_en) begin
          // Results are loaded on entry to DONE so they are valid with the pulse.
          state_d = StDone;
          bin_d   = sr_shift[BIN_W-1:0];
          err_d   = 1'b0;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = (state_q == StDone);
  assign bus.bin_out = bin_q;
  assign bus.err     = err_q;

`ifndef SYNTHESIS
  a_bcd_drained: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StShift && !corr_en) |-> (sr_shift[SR_W-1:BIN_W] == '0));
`endif

endmodule

// File: tb/tb_bcd_a_binario_seq.sv
module tb_bcd_a_binario_seq;

  localparam int unsigned DIGITS = 3;
  localparam int unsigned BIN_W  = 10;
  localparam int          LAT_OK  = 11;
  localparam int          LAT_BAD = 1;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  bcd_a_binario_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_a_binario_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bcd;
    int unsigned bin;
    bit          err;
    int          edges;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Decimal meaning of a packed BCD word; any non-decimal digit flags an error.
  function automatic void ref_conv(input logic [11:0] b, output int unsigned v, output bit e);
    int unsigned d;
    v = 0;
    e = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = (b >> (4 * i)) & 12'hF;
      if (d > 9) e = 1'b1;
      v = v * 10 + d;
    end
    if (e) v = 0;
  endfunction

  function automatic logic [11:0] to_bcd(input int unsigned n);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r = r | 12'((n % 10) << (4 * i));
      n = n / 10;
    end
    return r;
  endfunction

  task automatic convert(input logic [11:0] b, input int unsigned exp_bin, input bit exp_err,
                         input int exp_edges, input string tag);
    int edges;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    edges = 1;
    busy_cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    chk({tag, " done seen"}, 32'(seen), 1);
    chk({tag, " latency"}, edges, exp_edges);
    chk({tag, " busy cycles"}, busy_cnt, exp_edges);
    chk({tag, " bin_out"}, 32'(bus.bin_out), exp_bin);
    chk({tag, " err"}, 32'(bus.err), 32'(exp_err));
    @(negedge clk);
    chk({tag, " idle after done"}, {30'd0, bus.busy, bus.done}, 0);
  endtask

  initial begin
    int unsigned mv;
    bit me;
    int q[$];
    int idx, got, cyc, ndone, nbusy, edges;
    bit prev_done, first, acc, seen;
    logic [11:0] rb;

    n_checks = 0;
    n_fail = 0;
    bus.start = 1'b0;
    bus.bcd_in = '0;
    rst_n = 1'b0;

    tbl[0] = '{12'h000, 0,   1'b0, LAT_OK};
    tbl[1] = '{12'h255, 255, 1'b0, LAT_OK};
    tbl[2] = '{12'h999, 999, 1'b0, LAT_OK};
    tbl[3] = '{12'h1A5, 0,   1'b1, LAT_BAD};
    tbl[4] = '{12'h042, 42,  1'b0, LAT_OK};
    tbl[5] = '{12'h00F, 0,   1'b1, LAT_BAD};
    tbl[6] = '{12'h001, 1,   1'b0, LAT_OK};
    tbl[7] = '{12'hA00, 0,   1'b1, LAT_BAD};
    tbl[8] = '{12'h900, 900, 1'b0, LAT_OK};
    tbl[9] = '{12'h518, 518, 1'b0, LAT_OK};

    #12;
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset done", 32'(bus.done), 0);
    chk("reset bin_out", 32'(bus.bin_out), 0);
    chk("reset err", 32'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      convert(tbl[i].bcd, tbl[i].bin, tbl[i].err, tbl[i].edges, $sformatf("vec%0d", i));
    end

    // Back-to-back sweep of every valid input with start held high.
    idx = 0;
    got = 0;
    cyc = 0;
    prev_done = 1'b0;
    first = 1'b1;
    @(negedge clk);
    bus.bcd_in = to_bcd(0);
    bus.start = 1'b1;
    while (got < 1000 && cyc < 20000) begin
      acc = 1'b0;
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("sweep spurious done", 1, 0);
        end else begin
          ref_conv(to_bcd(q.pop_front()), mv, me);
          chk($sformatf("sweep bin_out %0d", mv), 32'(bus.bin_out), mv);
          if (bus.err !== 1'b0) chk("sweep err", 32'(bus.err), 0);
        end
        got++;
      end
      if (!bus.busy && bus.start) begin
        if (!first) chk("sweep accept one cycle after done", 32'(prev_done), 1);
        first = 1'b0;
        q.push_back(idx);
        acc = 1'b1;
      end
      prev_done = bus.done;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 1000) bus.bcd_in = to_bcd(idx);
        else bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("sweep completed", got, 1000);
    bus.start = 1'b0;

    // Random words, including non-decimal digits.
    for (int i = 0; i < 40; i++) begin
      rb = 12'($urandom);
      ref_conv(rb, mv, me);
      convert(rb, mv, me, me ? LAT_BAD : LAT_OK, $sformatf("rand %03h", rb));
    end

    // A start while busy must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd_in = 12'h123;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.bcd_in = 12'h777;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.bcd_in = 12'h000;
    edges = 5;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      edges++;
    end
    chk("busy-start done seen", 32'(seen), 1);
    chk("busy-start latency", edges, LAT_OK);
    chk("busy-start bin_out", 32'(bus.bin_out), 123);
    chk("busy-start err", 32'(bus.err), 0);
    nbusy = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.busy) nbusy++;
    end
    chk("busy-start no queued conversion", nbusy, 0);

    // Reset in the middle of a conversion.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd_in = 12'h500;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre-reset busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("async reset busy", 32'(bus.busy), 0);
    chk("async reset done", 32'(bus.done), 0);
    chk("async reset bin_out", 32'(bus.bin_out), 0);
    chk("async reset err", 32'(bus.err), 0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    chk("aborted conversion silent", ndone, 0);
    convert(12'h500, 500, 1'b0, LAT_OK, "post-reset 500");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
